// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: moves whole frames from a show-ahead input FIFO into a
// streaming FFT sink, limits the number of frames inside the FFT, and
// captures the block exponent and frame-end events from the FFT source side.
// Optional feature macro: FFT_CTRL_OVERRUN_EN (sticky input-overrun flag).
//
// state  | meaning
// IDLE   | waiting for run, a full frame in the FIFO and FFT capacity
// STREAM | presenting frame beats to the FFT sink until eop is accepted
module fft_frame_ctrl #(
  parameter int FRAME_LEN    = 4096,
  parameter int CNT_W        = 13,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic             fft_clk,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] fifo_usedw,
  input  logic             fifo_wrfull,
  output logic             fifo_rdreq,
  input  logic             sink_ready,
  output logic             sink_valid,
  output logic             sink_sop,
  output logic             sink_eop,
  input  logic             source_valid,
  input  logic             source_sop,
  input  logic             source_eop,
  input  logic [5:0]       source_exp,
  output logic [5:0]       exp_reg,
  output logic             frame_done,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int               IF_W        = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(FRAME_LEN - 1);
  localparam logic [IF_W-1:0]  MAX_IF      = IF_W'(MAX_INFLIGHT);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IF_W-1:0]  inflight_q, inflight_d;
  logic [5:0]       exp_q, exp_d;
  logic             done_q, done_d;

  logic in_stream;
  logic at_sop;
  logic at_eop;
  logic beat_acc;
  logic eop_acc;
  logic src_end;
  logic start_ok;

  // Outputs are qualified with reset so they read 0 for the whole reset
  // interval, including the first cycle before the state flop is cleared.
  assign in_stream = (state_q == STREAM) && !reset;
  assign at_sop    = in_stream && (cnt_q == '0);
  assign at_eop    = in_stream && (cnt_q == LAST_CNT);
  assign beat_acc  = in_stream && sink_ready;
  assign eop_acc   = beat_acc && at_eop;
  assign src_end   = source_valid && source_eop;
  assign start_ok  = run && (fifo_usedw >= FRAME_LEN_C) && (inflight_q < MAX_IF);

  assign sink_valid = in_stream;
  assign sink_sop   = at_sop;
  assign sink_eop   = at_eop;
  assign fifo_rdreq = beat_acc;
  assign exp_reg    = reset ? 6'd0 : exp_q;
  assign frame_done = done_q && !reset;

  // Frame state and sample counter; the counter only moves on accepted beats
  // so sop/eop stay put under backpressure.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = STREAM;
      STREAM:  if (eop_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (beat_acc) begin
      cnt_d = at_eop ? '0 : cnt_q + 1'b1;
    end
  end

  // Frames inside the FFT: up on sink eop, down on source eop, saturating.
  always_comb begin
    inflight_d = inflight_q;
    if (eop_acc && !src_end) begin
      if (inflight_q < MAX_IF) inflight_d = inflight_q + 1'b1;
    end else if (src_end && !eop_acc) begin
      if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
    end
  end

  // Source-side capture: exponent arrives with sop, frame_done trails eop.
  always_comb begin
    exp_d  = exp_q;
    done_d = src_end;
    if (source_valid && source_sop) exp_d = source_exp;
  end

  // Register update with synchronous reset; an interrupted frame is dropped.
  always_ff @(posedge fft_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inflight_q <= '0;
      exp_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      exp_q      <= exp_d;
      done_q     <= done_d;
    end
  end

`ifdef FFT_CTRL_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Sticky overrun; a full flag in the same cycle as a clear keeps it set.
  always_comb begin
    ovr_d = ovr_q;
    if (clr_overrun) ovr_d = 1'b0;
    if (fifo_wrfull) ovr_d = 1'b1;
  end

  // Overrun flag register.
  always_ff @(posedge fft_clk) begin
    if (reset) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign overrun = ovr_q && !reset;
`else
  logic unused_ovr_inputs;
  assign unused_ovr_inputs = fifo_wrfull ^ clr_overrun;
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl with FRAME_LEN=8, MAX_INFLIGHT=2. Stimulus pushes
// expected sink beats and expected exponents into queues; a negedge monitor
// pops and compares whenever the DUT accepts a beat or pulses frame_done.
module tb_fft_frame_ctrl;

  localparam int FLEN = 8;
  localparam int CW   = 13;

`ifdef FFT_CTRL_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  logic          fft_clk;
  logic          reset;
  logic          run;
  logic [CW-1:0] fifo_usedw;
  logic          fifo_wrfull;
  logic          fifo_rdreq;
  logic          sink_ready;
  logic          sink_valid;
  logic          sink_sop;
  logic          sink_eop;
  logic          source_valid;
  logic          source_sop;
  logic          source_eop;
  logic [5:0]    source_exp;
  logic [5:0]    exp_reg;
  logic          frame_done;
  logic          overrun;
  logic          clr_overrun;

  int vecs = 0;
  int errs = 0;

  logic [1:0] beat_q[$];
  logic [5:0] exp_q[$];
  logic [5:0] exp_model;
  logic [1:0] mon_beat;
  logic [5:0] mon_exp;

  fft_frame_ctrl #(
    .FRAME_LEN   (FLEN),
    .CNT_W       (CW),
    .MAX_INFLIGHT(2)
  ) dut (
    .fft_clk     (fft_clk),
    .reset       (reset),
    .run         (run),
    .fifo_usedw  (fifo_usedw),
    .fifo_wrfull (fifo_wrfull),
    .fifo_rdreq  (fifo_rdreq),
    .sink_ready  (sink_ready),
    .sink_valid  (sink_valid),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .source_valid(source_valid),
    .source_sop  (source_sop),
    .source_eop  (source_eop),
    .source_exp  (source_exp),
    .exp_reg     (exp_reg),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial fft_clk = 1'b0;
  always #5 fft_clk = ~fft_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check(nm, 32'({sink_valid, sink_sop, sink_eop, fifo_rdreq, frame_done, overrun, exp_reg}), 32'd0);
  endtask

  // Monitor: every accepted beat and every frame_done pulse consumes one entry.
  always @(negedge fft_clk) begin
    if (fifo_rdreq) begin
      if (beat_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL beat_unexpected: got accepted beat sop=%0d eop=%0d, expected none", sink_sop, sink_eop);
      end else begin
        mon_beat = beat_q.pop_front();
        check("beat_sop_eop", 32'({sink_sop, sink_eop}), 32'(mon_beat));
      end
    end
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL done_unexpected: got frame_done=1, expected 0");
      end else begin
        mon_exp = exp_q.pop_front();
        check("done_exp_reg", 32'(exp_reg), 32'(mon_exp));
      end
    end
  end

  // One frame: optional source-eop pulse in the first cycle, optional stall at
  // beat 3, optional reset at a given beat; exp_lat is the expected number of
  // cycles from the first driven cycle to sink_valid.
  task automatic do_frame(input bit stall_en, input bit src_first, input bit keep_run,
                          input int exp_lat, input int rst_at);
    int beats = 0;
    int cyc   = 0;
    int stall = 0;
    int start = -1;
    for (int i = 0; i < FLEN; i++) begin
      beat_q.push_back({(i == 0), (i == FLEN - 1)});
    end
    while (beats < FLEN && cyc < 60) begin
      @(posedge fft_clk); #1;
      if (cyc == 0) run = 1'b1;
      else if (start >= 0 && !keep_run) run = 1'b0;
      source_valid = src_first && (cyc == 0);
      source_eop   = src_first && (cyc == 0);
      if (src_first && cyc == 0) exp_q.push_back(exp_model);
      sink_ready = !(stall_en && beats == 3 && stall < 3);
      if (rst_at >= 0 && beats == rst_at) begin
        reset = 1'b1;
        run   = 1'b0;
        beat_q.delete();
        @(negedge fft_clk);
        check_zero("rst_mid_hold");
        @(posedge fft_clk); #1;
        reset     = 1'b0;
        exp_model = 6'd0;
        @(negedge fft_clk);
        check_zero("rst_mid_idle");
        return;
      end
      @(negedge fft_clk);
      if (sink_valid && start < 0) begin
        start = cyc;
        if (exp_lat >= 0) check("start_latency", 32'(cyc), 32'(exp_lat));
      end
      if (!sink_ready) begin
        stall++;
        check("stall_hold", 32'({sink_valid, fifo_rdreq, sink_sop, sink_eop}), 32'b1000);
      end
      if (fifo_rdreq) beats++;
      cyc++;
    end
    if (start < 0) check("start_latency", 32'(start), 32'(exp_lat));
    check("frame_beats", 32'(beats), 32'(FLEN));
    @(posedge fft_clk); #1;
    source_valid = 1'b0;
    source_eop   = 1'b0;
    @(negedge fft_clk);
    check("idle_after", 32'(sink_valid), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    run          = 1'b0;
    fifo_usedw   = '0;
    fifo_wrfull  = 1'b0;
    sink_ready   = 1'b1;
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    source_exp   = 6'd0;
    clr_overrun  = 1'b0;
    exp_model    = 6'd0;

    repeat (3) @(negedge fft_clk);
    check_zero("rst_hold");
    @(posedge fft_clk); #1;
    reset = 1'b0;
    @(negedge fft_clk);
    check_zero("rst_idle");

    // Plain frame, run dropped after the first beat.
    fifo_usedw = 13'd8;
    do_frame(1'b0, 1'b0, 1'b0, 1, -1);

    // Source side: exponent 5 with sop, eop carries a different exponent.
    @(posedge fft_clk); #1;
    source_valid = 1'b1; source_sop = 1'b1; source_exp = 6'd5; exp_model = 6'd5;
    @(posedge fft_clk); #1;
    source_sop = 1'b0; source_eop = 1'b1; source_exp = 6'd9;
    exp_q.push_back(exp_model);
    @(negedge fft_clk);
    check("exp_load", 32'(exp_reg), 32'd5);
    @(posedge fft_clk); #1;
    source_valid = 1'b0; source_eop = 1'b0; source_sop = 1'b1; source_exp = 6'd7;
    @(negedge fft_clk);
    check("exp_hold_eop", 32'(exp_reg), 32'd5);
    @(posedge fft_clk); #1;
    source_sop = 1'b0; source_exp = 6'd0;
    @(negedge fft_clk);
    check("done_one_cycle", 32'(frame_done), 32'd0);
    check("exp_hold_novalid", 32'(exp_reg), 32'd5);

    // Stalled frame with run held, then the back-to-back frame one idle cycle later.
    fifo_usedw = 13'd16;
    do_frame(1'b1, 1'b0, 1'b1, 1, -1);
    do_frame(1'b0, 1'b0, 1'b0, 0, -1);

    // Two frames in flight: no third start.
    for (int i = 0; i < 10; i++) begin
      @(posedge fft_clk); #1;
      run = 1'b1;
      @(negedge fft_clk);
      check("no_third_start", 32'(sink_valid), 32'd0);
    end
    do_frame(1'b0, 1'b1, 1'b0, 2, -1);

    // Reset at beat 4, then a clean frame.
    do_frame(1'b0, 1'b1, 1'b0, 2, 4);
    do_frame(1'b0, 1'b0, 1'b0, 1, -1);

    // Overrun flag.
    @(posedge fft_clk); #1;
    fifo_wrfull = 1'b1;
    @(negedge fft_clk);
    check("ovr_pre", 32'(overrun), 32'd0);
    @(posedge fft_clk); #1;
    fifo_wrfull = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge fft_clk);
      check("ovr_sticky", 32'(overrun), 32'(OVR));
      @(posedge fft_clk); #1;
    end
    clr_overrun = 1'b1; fifo_wrfull = 1'b1;
    @(posedge fft_clk); #1;
    clr_overrun = 1'b0; fifo_wrfull = 1'b0;
    @(negedge fft_clk);
    check("ovr_set_wins", 32'(overrun), 32'(OVR));
    @(posedge fft_clk); #1;
    clr_overrun = 1'b1;
    @(posedge fft_clk); #1;
    clr_overrun = 1'b0;
    @(negedge fft_clk);
    check("ovr_clear", 32'(overrun), 32'd0);

    repeat (3) @(negedge fft_clk);
    check("beat_q_drained", 32'(beat_q.size()), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
